// File: rtl/bitwise_logic_stream.sv
// Streaming bitwise logic engine: per-beat two-operand op, multi-beat packet reduction,
// registered valid/ready result with zero/parity flags and a saturating beat count.
module bitwise_logic_stream #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_cmb,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       cmb_q, cmb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] beat_val;
  logic [WIDTH-1:0] comb_val;

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    beat_val = '0;
    unique case (in_op)
      3'd0: beat_val = in_a & in_b;
      3'd1: beat_val = in_a | in_b;
      3'd2: beat_val = in_a ^ in_b;
      3'd3: beat_val = ~(in_a & in_b);
      3'd4: beat_val = ~(in_a | in_b);
      3'd5: beat_val = ~(in_a ^ in_b);
      3'd6: beat_val = in_a & ~in_b;
      3'd7: beat_val = in_a;
      default: beat_val = '0;
    endcase
  end

  // Reserved combine code 3 falls back to OR.
  always_comb begin
    comb_val = acc_q | beat_val;
    unique case (cmb_q)
      2'd1:    comb_val = acc_q & beat_val;
      2'd2:    comb_val = acc_q ^ beat_val;
      default: comb_val = acc_q | beat_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? StIdle : StAccum;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cmb_d = cmb_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    emit  = 1'b0;
    if (accept) begin
      emit = in_last;
      if (state_q == StIdle) begin
        acc_d = beat_val;
        cmb_d = in_cmb;
        cnt_d = CntOne;
        sat_d = 1'b0;
      end else begin
        acc_d = comb_val;
        if (cnt_q == CntMax) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cmb_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cmb_q <= cmb_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // A new emit takes priority over a drain in the same cycle, keeping out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_beats  <= '0;
      out_sat    <= 1'b0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_result <= acc_d;
      out_zero   <= (acc_d == '0);
      out_parity <= ^acc_d;
      out_beats  <= cnt_d;
      out_sat    <= sat_d;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_stream.sv
// Scoreboard bench: two engines (CNT_W=8 and CNT_W=2) share stimulus, each with its own
// expected-result queue drained by a monitor on every output handshake.
module tb_bitwise_logic_stream;

  typedef struct packed {
    logic [17:0] result;
    logic        zero;
    logic        parity;
    logic [7:0]  beats;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [17:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [1:0]  in_cmb;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, rdy1, ov0, ov1, z0, z1, p0, p1, s0, s1;
  logic [17:0] r0, r1;
  logic [7:0]  b0;
  logic [1:0]  b1;
  logic        in_ready;

  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  assign in_ready = sel ? rdy1 : rdy0;

  bitwise_logic_stream #(.WIDTH(18), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cmb(in_cmb), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_result(r0), .out_zero(z0),
    .out_parity(p0), .out_beats(b0), .out_sat(s0)
  );

  bitwise_logic_stream #(.WIDTH(18), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cmb(in_cmb), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_result(r1), .out_zero(z1),
    .out_parity(p1), .out_beats(b1), .out_sat(s1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: one pop per output handshake (out_ready is stable around the negedge).
  always @(negedge clk) begin
    if (rst_n && ov0 && out_ready) begin
      exp_t act;
      act = '{result: r0, zero: z0, parity: p0, beats: b0, sat: s0};
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_unexpected_output: got %h expected none", act);
      end else begin
        check("dut0_result", 64'(act), 64'(q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && out_ready) begin
      exp_t act;
      act = '{result: r1, zero: z1, parity: p1, beats: {6'd0, b1}, sat: s1};
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_output: got %h expected none", act);
      end else begin
        check("dut1_result", 64'(act), 64'(q1.pop_front()));
      end
    end
  end

  task automatic expect_out(input logic [17:0] res, input logic z, input logic p,
                            input logic [7:0] beats, input logic sat);
    exp_t e;
    e = '{result: res, zero: z, parity: p, beats: beats, sat: sat};
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // Called just after a posedge; returns just after the edge that accepted the beat.
  task automatic beat(input logic [2:0] op, input logic [1:0] cmb, input logic [17:0] a,
                      input logic [17:0] b, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1; in_op = op; in_cmb = cmb; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = '0; in_cmb = '0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check("reset_in_ready", 64'(rdy0), 64'd0);
    check("reset_outputs", 64'({ov0, r0, z0, p0, b0, s0}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single-beat packets, back to back.
    expect_out(18'h3FFFF, 1'b0, 1'b0, 8'd1, 1'b0);
    beat(3'd1, 2'd0, 18'h2AAAA, 18'h15555, 1'b1);
    expect_out(18'h00000, 1'b1, 1'b0, 8'd1, 1'b0);
    beat(3'd0, 2'd3, 18'h3F000, 18'h00FFF, 1'b1);
    expect_out(18'h3FFF0, 1'b0, 1'b0, 8'd1, 1'b0);
    beat(3'd6, 2'd1, 18'h3FFFF, 18'h0000F, 1'b1);
    expect_out(18'h3C3C3, 1'b0, 1'b0, 8'd1, 1'b0);
    beat(3'd4, 2'd0, 18'h00000, 18'h03C3C, 1'b1);

    // Three-beat XOR-combined packet.
    beat(3'd7, 2'd2, 18'h00001, 18'h3FFFF, 1'b0);
    beat(3'd7, 2'd0, 18'h00003, 18'h00000, 1'b0);
    expect_out(18'h00005, 1'b0, 1'b0, 8'd3, 1'b0);
    beat(3'd7, 2'd1, 18'h00007, 18'h00000, 1'b1);
    idle(2);

    // Backpressure: hold 0x12345 while the next packet waits.
    out_ready = 1'b0;
    expect_out(18'h12345, 1'b0, 1'b1, 8'd1, 1'b0);
    beat(3'd7, 2'd0, 18'h12345, 18'h00000, 1'b1);
    expect_out(18'h00111, 1'b0, 1'b1, 8'd1, 1'b0);
    in_valid = 1'b1; in_op = 3'd1; in_a = 18'h00100; in_b = 18'h00011; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_hold", 64'({ov0, r0, p0, b0}), 64'({1'b1, 18'h12345, 1'b1, 8'd1}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    idle(3);
    check("bp_queue_drained", 64'(q0.size()), 64'd0);

    // Saturation on the CNT_W=2 engine, then a fresh packet clears it.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) beat(3'd0, 2'd1, 18'h3FFFF, 18'h3FFFF, 1'b0);
    expect_out(18'h3FFFF, 1'b0, 1'b0, 8'd3, 1'b1);
    beat(3'd0, 2'd1, 18'h3FFFF, 18'h3FFFF, 1'b1);
    expect_out(18'h00003, 1'b0, 1'b0, 8'd1, 1'b0);
    beat(3'd7, 2'd0, 18'h00003, 18'h00000, 1'b1);
    idle(2);
    check("sat_queue_drained", 64'(q1.size()), 64'd0);
    sel = 1'b0;

    // Reset mid-packet discards the open packet.
    beat(3'd1, 2'd0, 18'h3FFFF, 18'h00000, 1'b0);
    beat(3'd1, 2'd0, 18'h3FFFF, 18'h00000, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 64'(ov0), 64'd0);
    @(posedge clk); #1;
    expect_out(18'h0000F, 1'b0, 1'b0, 8'd1, 1'b0);
    beat(3'd2, 2'd0, 18'h00F00, 18'h00F0F, 1'b1);
    idle(3);
    check("final_queue0", 64'(q0.size()), 64'd0);
    check("final_queue1", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
